// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 burst types, response codes and helpers
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Severity follows the numeric encoding: DECERR > SLVERR > OKAY.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic burst_illegal(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst, input logic [2:0] max_size);
    return (size > max_size) || (burst == 2'b11) || ((burst == WRAP) && !wrap_len_ok(len));
  endfunction

endpackage

// File: rtl/axi4_burst_ram_if.sv
// rtl/axi4_burst_ram_if.sv - AXI4 five-channel bundle with master/slave views
interface axi4_burst_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_payload_addr;
  logic [7:0]              aw_payload_len;
  logic [2:0]              aw_payload_size;
  logic [1:0]              aw_payload_burst;
  logic [ID_WIDTH-1:0]     aw_payload_id;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_payload_data;
  logic [DATA_WIDTH/8-1:0] w_payload_strb;
  logic                    w_payload_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_payload_resp;
  logic [ID_WIDTH-1:0]     b_payload_id;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_payload_addr;
  logic [7:0]              ar_payload_len;
  logic [2:0]              ar_payload_size;
  logic [1:0]              ar_payload_burst;
  logic [ID_WIDTH-1:0]     ar_payload_id;

  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_payload_data;
  logic [1:0]              r_payload_resp;
  logic                    r_payload_last;
  logic [ID_WIDTH-1:0]     r_payload_id;

  modport master (
    output aw_valid, aw_payload_addr, aw_payload_len, aw_payload_size, aw_payload_burst, aw_payload_id,
    input  aw_ready,
    output w_valid, w_payload_data, w_payload_strb, w_payload_last,
    input  w_ready,
    input  b_valid, b_payload_resp, b_payload_id,
    output b_ready,
    output ar_valid, ar_payload_addr, ar_payload_len, ar_payload_size, ar_payload_burst, ar_payload_id,
    input  ar_ready,
    input  r_valid, r_payload_data, r_payload_resp, r_payload_last, r_payload_id,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_payload_addr, aw_payload_len, aw_payload_size, aw_payload_burst, aw_payload_id,
    output aw_ready,
    input  w_valid, w_payload_data, w_payload_strb, w_payload_last,
    output w_ready,
    output b_valid, b_payload_resp, b_payload_id,
    input  b_ready,
    input  ar_valid, ar_payload_addr, ar_payload_len, ar_payload_size, ar_payload_burst, ar_payload_id,
    output ar_ready,
    output r_valid, r_payload_data, r_payload_resp, r_payload_last, r_payload_id,
    input  r_ready
  );
endinterface

// File: rtl/axi4_burst_addr.sv
// rtl/axi4_burst_addr.sv - combinational next-beat address for FIXED/INCR/WRAP
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH-1:0] mask;

  assign step = ADDR_WIDTH'(1) << size_i;
  assign sum  = addr_i + step;
  // Legal wrap lengths make the window a power of two, so it reduces to a mask.
  assign mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_o = sum;
    if (burst_i == FIXED) begin
      next_addr_o = addr_i;
    end else if ((burst_i == WRAP) && wrap_len_ok(len_i)) begin
      next_addr_o = (addr_i & ~mask) | (sum & mask);
    end
  end

endmodule

// File: rtl/axi4_burst_ram.sv
// rtl/axi4_burst_ram.sv - AXI4 slave RAM with independent read and write burst engines
module axi4_burst_ram
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int ID_WIDTH   = 4
) (
  input  logic            clk,
  input  logic            reset,
  axi4_burst_ram_if.slave io_axi
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BLOG  = $clog2(BYTES);
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [2:0] MAX_SIZE = 3'(BLOG);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e               wstate_q;
  logic                  aw_ready_q, w_ready_q, b_valid_q, wbad_q;
  logic [1:0]            b_resp_q, wresp_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic [ID_WIDTH-1:0]   wid_q;

  logic       aw_hs, w_hs, w_final, w_dec, w_mis, mem_we;
  logic [1:0] w_beat_resp;

  assign aw_hs       = io_axi.aw_valid & aw_ready_q;
  assign w_hs        = io_axi.w_valid & w_ready_q;
  assign w_final     = (wcnt_q == wlen_q);
  assign w_dec       = (waddr_q >= MEM_LIMIT);
  assign w_mis       = (io_axi.w_payload_last != w_final);
  assign w_beat_resp = w_dec ? RESP_DECERR : ((wbad_q | w_mis) ? RESP_SLVERR : RESP_OKAY);
  assign mem_we      = w_hs & ~w_dec & ~wbad_q;

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr_i      (waddr_q),
    .size_i      (wsize_q),
    .len_i       (wlen_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_q   <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      wresp_q    <= RESP_OKAY;
      wbad_q     <= 1'b0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wcnt_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wid_q      <= '0;
    end else begin
      unique case (wstate_q)
        W_IDLE: begin
          aw_ready_q <= 1'b1;
          if (aw_hs) begin
            waddr_q    <= io_axi.aw_payload_addr;
            wlen_q     <= io_axi.aw_payload_len;
            wsize_q    <= io_axi.aw_payload_size;
            wburst_q   <= io_axi.aw_payload_burst;
            wid_q      <= io_axi.aw_payload_id;
            wbad_q     <= burst_illegal(io_axi.aw_payload_size, io_axi.aw_payload_len,
                                        io_axi.aw_payload_burst, MAX_SIZE);
            wcnt_q     <= '0;
            wresp_q    <= RESP_OKAY;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            wstate_q   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_q + 8'd1;
            wresp_q <= resp_max(wresp_q, w_beat_resp);
            if (w_final) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_resp_q  <= resp_max(wresp_q, w_beat_resp);
              wstate_q  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (io_axi.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            wstate_q   <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (io_axi.w_payload_strb[b]) begin
          mem[waddr_q[BLOG +: IDX_W]][8*b +: 8] <= io_axi.w_payload_data[8*b +: 8];
        end
      end
    end
  end

  assign io_axi.aw_ready       = aw_ready_q;
  assign io_axi.w_ready        = w_ready_q;
  assign io_axi.b_valid        = b_valid_q;
  assign io_axi.b_payload_resp = b_resp_q;
  assign io_axi.b_payload_id   = wid_q;

  rstate_e               rstate_q;
  logic                  ar_ready_q, r_valid_q, r_last_q, rbad_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rcur_addr;
  logic [7:0]            rlen_q, rcnt_q, rcur_len;
  logic [2:0]            rsize_q, rcur_size;
  logic [1:0]            rburst_q, rcur_burst, rcur_resp;
  logic                  rcur_bad, rcur_dec, ar_hs, r_hs;
  logic [DATA_WIDTH-1:0] rcur_data;

  assign ar_hs = io_axi.ar_valid & ar_ready_q;
  assign r_hs  = r_valid_q & io_axi.r_ready;

  // In idle the fetch path looks straight at AR so beat 0 registers on the handshake.
  always_comb begin
    rcur_addr  = raddr_q;
    rcur_len   = rlen_q;
    rcur_size  = rsize_q;
    rcur_burst = rburst_q;
    rcur_bad   = rbad_q;
    if (rstate_q == R_IDLE) begin
      rcur_addr  = io_axi.ar_payload_addr;
      rcur_len   = io_axi.ar_payload_len;
      rcur_size  = io_axi.ar_payload_size;
      rcur_burst = io_axi.ar_payload_burst;
      rcur_bad   = burst_illegal(io_axi.ar_payload_size, io_axi.ar_payload_len,
                                 io_axi.ar_payload_burst, MAX_SIZE);
    end
  end

  assign rcur_dec  = (rcur_addr >= MEM_LIMIT);
  assign rcur_resp = rcur_dec ? RESP_DECERR : (rcur_bad ? RESP_SLVERR : RESP_OKAY);
  assign rcur_data = (rcur_dec | rcur_bad) ? '0 : mem[rcur_addr[BLOG +: IDX_W]];

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr_i      (rcur_addr),
    .size_i      (rcur_size),
    .len_i       (rcur_len),
    .burst_i     (rcur_burst),
    .next_addr_o (raddr_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_q   <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      rid_q      <= '0;
      rbad_q     <= 1'b0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rcnt_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
    end else begin
      unique case (rstate_q)
        R_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_hs) begin
            rlen_q     <= io_axi.ar_payload_len;
            rsize_q    <= io_axi.ar_payload_size;
            rburst_q   <= io_axi.ar_payload_burst;
            rid_q      <= io_axi.ar_payload_id;
            rbad_q     <= rcur_bad;
            raddr_q    <= raddr_d;
            rcnt_q     <= '0;
            r_data_q   <= rcur_data;
            r_resp_q   <= rcur_resp;
            r_last_q   <= (io_axi.ar_payload_len == 8'd0);
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            rstate_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              rstate_q   <= R_IDLE;
            end else begin
              r_data_q <= rcur_data;
              r_resp_q <= rcur_resp;
              r_last_q <= ((rcnt_q + 8'd1) == rlen_q);
              rcnt_q   <= rcnt_q + 8'd1;
              raddr_q  <= raddr_d;
            end
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign io_axi.ar_ready       = ar_ready_q;
  assign io_axi.r_valid        = r_valid_q;
  assign io_axi.r_payload_data = r_data_q;
  assign io_axi.r_payload_resp = r_resp_q;
  assign io_axi.r_payload_last = r_last_q;
  assign io_axi.r_payload_id   = rid_q;

endmodule
